// File: rtl/fetch_defs.sv
// Shared widths, FSM encodings and queue entry layout for the instruction fetch unit.
package fetch_defs;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned ENTRY_W = ADDR_W + WORD_W;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [WORD_W-1:0] word;
    } fetch_entry_t;

    // True when a word address lies inside the instruction memory.
    function automatic logic pc_in_mem(input logic [ADDR_W-1:0] pc,
                                       input int unsigned        mem_words);
        return pc < ADDR_W'(mem_words);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instruction} entries; push and pop may coincide even when full.
module fetch_queue
    import fetch_defs::*;
#(
    parameter int unsigned DEPTH = 4
)(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    input  fetch_entry_t         din,
    output fetch_entry_t         dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                 empty,
    output logic                 full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & ~flush & (~full | do_pop);

    // Head reads as zero when empty so stale entries never leak out.
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch requester: PC, RUN/HALT control, prefetch queue and redirect handling.
module instr_fetch
    import fetch_defs::*;
#(
    parameter int unsigned MEM_WORDS = 11,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned RESET_PC  = 0
)(
    input  logic              clk,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] address,
    input  logic [WORD_W-1:0] instruction,
    output logic [WORD_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fetch_done
);

    localparam int unsigned         CNT_W  = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0]   END_PC = ADDR_W'(MEM_WORDS);

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic              pop_c;
    logic              push_c;
    logic [CNT_W-1:0]  q_count;
    logic              q_empty;
    logic              q_full;
    fetch_entry_t      q_din;
    fetch_entry_t      q_dout;

    assign address     = pc;
    assign pc_inc      = pc + ADDR_W'(1);
    assign instr_valid = (q_count != '0);
    assign instr_out   = q_dout.word;
    assign instr_pc    = q_dout.pc;
    assign fetch_done  = (state == S_HALT);

    assign pop_c  = ~q_empty & instr_ready;
    assign push_c = (state == S_RUN) & ~redirect & pc_in_mem(pc, MEM_WORDS)
                  & (~q_full | pop_c);

    assign q_din = '{pc: pc, word: instruction};

    // PC and RUN/HALT control; redirect overrides everything except reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc    <= ADDR_W'(RESET_PC);
            state <= S_RUN;
        end else if (redirect) begin
            pc    <= redirect_pc;
            state <= pc_in_mem(redirect_pc, MEM_WORDS) ? S_RUN : S_HALT;
        end else if (state == S_RUN) begin
            if (!pc_in_mem(pc, MEM_WORDS)) begin
                state <= S_HALT;
            end else if (push_c) begin
                pc <= pc_inc;
                if (pc_inc == END_PC) begin
                    state <= S_HALT;
                end
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_c),
        .pop     (pop_c),
        .flush   (redirect),
        .din     (q_din),
        .dout    (q_dout),
        .count   (q_count),
        .empty   (q_empty),
        .full    (q_full)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch against an 11-word instruction memory.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] address;
    logic [31:0] instruction;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] got_pc[$];
    logic [31:0] got_ins[$];
    logic        got_done[$];

    always #5 clk = ~clk;

    assign instruction = (address < 32'd11) ? (32'hA000_0000 + address) : 32'h0;

    instr_fetch dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .address     (address),
        .instruction (instruction),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_done  (fetch_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        reset_n     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        instr_ready = ready;
        step();
        step();
        check("rst valid", 32'(instr_valid), 32'd0);
        check("rst done",  32'(fetch_done),  32'd0);
        check("rst addr",  address,          32'd0);
        check("rst instr", instr_out,        32'd0);
        check("rst pc",    instr_pc,         32'd0);
        reset_n = 1'b1;
    endtask

    task automatic collect(input int cycles);
        got_pc.delete();
        got_ins.delete();
        got_done.delete();
        for (int i = 0; i < cycles; i++) begin
            if (instr_valid && instr_ready) begin
                got_pc.push_back(instr_pc);
                got_ins.push_back(instr_out);
                got_done.push_back(fetch_done);
            end
            step();
        end
    endtask

    task automatic verify_seq(input string tag, input int first, input int n);
        check($sformatf("%s count", tag), 32'(got_pc.size()), 32'(n));
        for (int i = 0; i < n && i < got_pc.size(); i++) begin
            check($sformatf("%s pc[%0d]", tag, i), got_pc[i], 32'(first + i));
            check($sformatf("%s ins[%0d]", tag, i), got_ins[i], 32'hA000_0000 + 32'(first + i));
        end
    endtask

    initial begin
        bit stable;

        // Streaming from reset with decode always ready.
        do_reset(1'b1);
        check("t1 valid before push", 32'(instr_valid), 32'd0);
        step();
        check("t1 first valid", 32'(instr_valid), 32'd1);
        check("t1 first pc",    instr_pc,         32'd0);
        check("t1 first ins",   instr_out,        32'hA000_0000);
        collect(16);
        verify_seq("t1", 0, 11);
        if (got_done.size() == 11) begin
            check("t1 done at pc9",  32'(got_done[9]),  32'd0);
            check("t1 done at pc10", 32'(got_done[10]), 32'd1);
        end
        check("t1 drained", 32'(instr_valid), 32'd0);
        check("t1 halted",  32'(fetch_done),  32'd1);

        // Backpressure from reset: queue fills and the head holds still.
        do_reset(1'b0);
        stable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i >= 4 && !(instr_valid && instr_out == 32'hA000_0000 && instr_pc == 32'd0))
                stable = 1'b0;
        end
        check("t2 addr stall", address,          32'd4);
        check("t2 head stable", 32'(stable),     32'd1);
        check("t2 head ins",   instr_out,        32'hA000_0000);
        instr_ready = 1'b1;
        collect(16);
        verify_seq("t2", 0, 11);

        // Full queue with decode ready: push and pop every cycle.
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) step();
        check("t3 addr full", address, 32'd4);
        instr_ready = 1'b1;
        step();
        check("t3 head1", instr_pc, 32'd1);
        check("t3 addr1", address,  32'd5);
        step();
        check("t3 head2", instr_pc, 32'd2);
        check("t3 addr2", address,  32'd6);

        // Redirect to 7 while the queue holds pcs 2..5.
        redirect    = 1'b1;
        redirect_pc = 32'd7;
        check("t4 head consumed", instr_pc, 32'd2);
        step();
        redirect = 1'b0;
        check("t4 flushed", 32'(instr_valid), 32'd0);
        check("t4 addr",    address,          32'd7);
        check("t4 running", 32'(fetch_done),  32'd0);
        step();
        check("t4 new valid", 32'(instr_valid), 32'd1);
        check("t4 new pc",    instr_pc,         32'd7);
        check("t4 new ins",   instr_out,        32'hA000_0007);
        collect(12);
        verify_seq("t4", 7, 4);
        check("t4 halted", 32'(fetch_done), 32'd1);

        // Redirect out of range keeps HALT; redirect in range resumes.
        redirect    = 1'b1;
        redirect_pc = 32'd12;
        step();
        redirect = 1'b0;
        step();
        step();
        check("t5 done oor",  32'(fetch_done),  32'd1);
        check("t5 valid oor", 32'(instr_valid), 32'd0);
        check("t5 addr oor",  address,          32'd12);
        redirect    = 1'b1;
        redirect_pc = 32'd9;
        step();
        redirect = 1'b0;
        check("t5 done resume", 32'(fetch_done), 32'd0);
        check("t5 addr resume", address,         32'd9);
        collect(8);
        verify_seq("t5", 9, 2);
        check("t5 done end", 32'(fetch_done), 32'd1);

        // Reset pulse mid-stream with three entries queued.
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) step();
        check("t6 addr pre", address,          32'd3);
        check("t6 valid pre", 32'(instr_valid), 32'd1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("t6 valid post", 32'(instr_valid), 32'd0);
        check("t6 addr post",  address,          32'd0);
        check("t6 ins post",   instr_out,        32'd0);
        instr_ready = 1'b1;
        collect(16);
        verify_seq("t6", 0, 11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
